imem_loader: RTL

Boot-time program loader that sits directly upstream of the MIPS core's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles it into 32-bit big-endian words. It writes those words sequentially into instruction memory starting at word 0, then releases the core to run. While loading, the core is held idle via core_run=0, so Fetching never reads a partially written program.

---
 rtl/imem_loader.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// imem_loader: byte-stream boot loader writing big-endian 32-bit words into
// instruction memory, then releasing the core. Option: LOADER_CHECKSUM_EN.
// Revision: 1.0
// ============================================================================
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_run,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_LOAD, S_DONE, S_ERR
`ifdef LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  localparam logic [16:0] c_max_words = 17'(1) << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t c_end_state = S_CHK;
`else
  localparam state_t c_end_state = S_DONE;
`endif

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [31:0]       asm_q, asm_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d, addr_q, addr_d;
  logic              we_q, we_d, ready_q, ready_d, done_q, done_d, err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        w_accept;
  logic        w_last;
  logic [15:0] w_len;

  assign w_accept = byte_valid & ready_q;
  assign w_len    = {len_q[15:8], byte_data};
  assign w_last   = (17'(idx_q) + 17'd1) == {1'b0, len_q};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR0;
          idx_d   = '0;
          cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_HDR0: begin
        if (w_accept) begin
          len_d[15:8] = byte_data;
          state_d     = S_HDR1;
        end
      end
      S_HDR1: begin
        if (w_accept) begin
          len_d[7:0] = byte_data;
          if (w_len == 16'd0)                  state_d = c_end_state;
          else if (17'(w_len) > c_max_words)   state_d = S_ERR;
          else                                 state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          asm_d = {asm_q[23:0], byte_data};
          cnt_d = cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ byte_data;
`endif
          if (cnt_q == 2'd3) begin
            we_d   = 1'b1;
            addr_d = idx_q;
            // Index wraps naturally after the last word of a full-capacity load.
            idx_d  = idx_q + 1'b1;
            if (w_last) state_d = c_end_state;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_accept) state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_LOAD)
`ifdef LOADER_CHECKSUM_EN
              || (state_d == S_CHK)
`endif
              ;
    // Status rises one cycle after entering the terminal state and drops on start.
    done_d = (state_q == S_DONE) && (state_d == S_DONE);
    err_d  = (state_q == S_ERR)  && (state_d == S_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      asm_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign byte_ready = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = asm_q;
  assign core_run   = done_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
`default_nettype wire
